// File: rtl/led_level_meter.sv
// Bar-graph LED level meter: bar, peak-hold dot with timed decay, clip LED,
// all gated by a free-running PWM brightness.
module led_level_meter #(
    parameter int N_LEDS    = 8,
    parameter int DIN_W     = 6,
    parameter int HOLD_SMP  = 64,
    parameter int DECAY_SMP = 8,
    parameter int CLIP_SMP  = 128,
    parameter int PWM_W     = 4,
    parameter int CNT_W     = 8,
    localparam int LVL_W    = $clog2(N_LEDS)
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic [DIN_W-1:0]  dinput,
    input  logic [PWM_W-1:0]  brightness,
    output logic [N_LEDS-1:0] leds,
    output logic [LVL_W-1:0]  peak_lvl
);

    // state   | meaning
    // S_IDLE  | no peak held (peak = 0)
    // S_HOLD  | peak dot held, hold counter running
    // S_DECAY | peak dot stepping down one LED per DECAY_SMP samples
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_DECAY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_SMP);
    localparam logic [CNT_W-1:0] DECAY_LD = CNT_W'(DECAY_SMP);
    localparam logic [CNT_W-1:0] CLIP_LD  = CNT_W'(CLIP_SMP);

    state_t             r_state, w_state_nxt;
    logic [LVL_W-1:0]   r_lvl;
    logic [LVL_W-1:0]   r_peak, w_peak_nxt;
    logic [CNT_W-1:0]   r_hold, w_hold_nxt;
    logic [CNT_W-1:0]   r_dec, w_dec_nxt;
    logic [CNT_W-1:0]   r_clip;
    logic [PWM_W-1:0]   r_pwm;
    logic [N_LEDS-1:0]  r_leds;

    logic [LVL_W-1:0]   w_lvl;
    logic               w_clip_evt;
    logic               w_pwm_on;
    logic [N_LEDS-1:0]  w_bar;
    logic [N_LEDS-1:0]  w_dot;
    logic [N_LEDS-1:0]  w_clip_led;
    logic [N_LEDS-1:0]  w_leds_nxt;

    assign w_lvl      = dinput[DIN_W-1 -: LVL_W];
    assign w_clip_evt = &dinput;

    // Peak FSM: decisions use the incoming sample's level, not the stored one
    always_comb begin
        w_state_nxt = r_state;
        w_peak_nxt  = r_peak;
        w_hold_nxt  = r_hold;
        w_dec_nxt   = r_dec;
        if (din_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_lvl != '0) begin
                        w_peak_nxt  = w_lvl;
                        w_hold_nxt  = HOLD_LD;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if ((w_lvl >= r_peak) && (w_lvl != '0)) begin
                        w_peak_nxt = w_lvl;
                        w_hold_nxt = HOLD_LD;
                    end else if (r_hold <= CNT_W'(1)) begin
                        w_hold_nxt  = '0;
                        w_dec_nxt   = DECAY_LD;
                        w_state_nxt = S_DECAY;
                    end else begin
                        w_hold_nxt = r_hold - 1'b1;
                    end
                end
                S_DECAY: begin
                    if (w_lvl >= r_peak) begin
                        w_peak_nxt  = w_lvl;
                        w_hold_nxt  = HOLD_LD;
                        w_state_nxt = S_HOLD;
                    end else if (r_dec <= CNT_W'(1)) begin
                        w_peak_nxt = r_peak - 1'b1;
                        w_dec_nxt  = DECAY_LD;
                        if (r_peak == LVL_W'(1)) begin
                            w_dec_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_dec_nxt = r_dec - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_peak_nxt  = '0;
                    w_hold_nxt  = '0;
                    w_dec_nxt   = '0;
                end
            endcase
        end
    end

    // Top LED is reserved for clip, so the bar never reaches it
    always_comb begin
        w_bar = '0;
        for (int i = 0; i < N_LEDS - 1; i++) begin
            w_bar[i] = (LVL_W'(i) < r_lvl);
        end
        w_dot      = (r_peak != '0) ? (N_LEDS'(1) << (r_peak - 1'b1)) : '0;
        w_clip_led = {(r_clip != '0), {(N_LEDS-1){1'b0}}};
        w_pwm_on   = (&brightness) | (r_pwm < brightness);
        w_leds_nxt = (w_bar | w_dot | w_clip_led) & {N_LEDS{w_pwm_on}};
    end

    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lvl   <= '0;
            r_peak  <= '0;
            r_hold  <= '0;
            r_dec   <= '0;
            r_clip  <= '0;
            r_pwm   <= '0;
            r_leds  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_peak  <= w_peak_nxt;
            r_hold  <= w_hold_nxt;
            r_dec   <= w_dec_nxt;
            r_pwm   <= r_pwm + 1'b1;
            r_leds  <= w_leds_nxt;
            if (din_valid) begin
                r_lvl <= w_lvl;
                if (w_clip_evt) begin
                    r_clip <= CLIP_LD;
                end else if (r_clip != '0) begin
                    r_clip <= r_clip - 1'b1;
                end
            end
        end
    end

    assign leds     = r_leds;
    assign peak_lvl = r_peak;

endmodule

// File: tb/tb_led_level_meter.sv
// Directed bench for led_level_meter: table of valid samples with expected
// LED/peak values, plus reset, latency, idle-hold and PWM sequences.
module tb_led_level_meter;

    logic       dclk;
    logic       rst_n;
    logic       din_valid;
    logic [5:0] dinput;
    logic [3:0] brightness;
    logic [7:0] leds;
    logic [2:0] peak_lvl;

    int errors = 0;
    int checks = 0;

    led_level_meter #(
        .N_LEDS(8), .DIN_W(6), .HOLD_SMP(4), .DECAY_SMP(2),
        .CLIP_SMP(3), .PWM_W(4), .CNT_W(8)
    ) dut (
        .dclk       (dclk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .dinput     (dinput),
        .brightness (brightness),
        .leds       (leds),
        .peak_lvl   (peak_lvl)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    typedef struct {
        bit         rst;
        logic [5:0] din;
        logic [7:0] exp_leds;
        logic [2:0] exp_peak;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [5:0] din,
                       input logic [7:0] l, input logic [2:0] p);
        vec_t v;
        v.rst = rst; v.din = din; v.exp_leds = l; v.exp_peak = p;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [5:0] din,
                         input logic [7:0] l, input logic [2:0] p);
        for (int k = 0; k < n; k++) add(1'b0, din, l, p);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // One valid edge followed by one idle edge so leds reflect the sample
    task automatic sample(input logic [5:0] d);
        din_valid = 1'b1;
        dinput = d;
        tick();
        din_valid = 1'b0;
        dinput = 6'd0;
        tick();
    endtask

    task automatic pwm_window(input string name, input int exp_on);
        int on_cnt, bad_cnt;
        on_cnt = 0; bad_cnt = 0;
        tick(); tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            if (leds == 8'h7F) on_cnt++;
            else if (leds != 8'h00) bad_cnt++;
        end
        check({name, "_on"}, exp_on, on_cnt, exp_on);
        check({name, "_bad"}, exp_on, bad_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        din_valid = 1'b0;
        dinput = 6'd0;
        brightness = 4'hF;

        // Reset held 2 edges with a clip-level sample present
        din_valid = 1'b1;
        dinput = 6'd63;
        tick(); tick();
        check("rst_leds", 0, leds, 8'h00);
        check("rst_peak", 0, peak_lvl, 3'd0);

        // First valid edge after release: peak now, leds one edge later
        rst_n = 1'b1;
        tick();
        check("lat_peak", 0, peak_lvl, 3'd7);
        check("lat_leds", 0, leds, 8'h00);
        din_valid = 1'b0;
        dinput = 6'd0;
        tick();
        check("lat_leds", 1, leds, 8'hFF);

        // No valid strobe: nothing but PWM may change
        dinput = 6'd8;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_leds", k, leds, 8'hFF);
            check("idle_peak", k, peak_lvl, 3'd7);
        end

        // Bar mapping
        add(1'b1, 6'd0, 8'h00, 3'd0);
        add(1'b0, 6'd0, 8'h00, 3'd0);
        add(1'b0, 6'd8, 8'h01, 3'd1);
        add(1'b0, 6'd27, 8'h07, 3'd3);
        add(1'b0, 6'd56, 8'h7F, 3'd7);
        // Hold then decay
        add(1'b1, 6'd0, 8'h00, 3'd0);
        add(1'b0, 6'd40, 8'h1F, 3'd5);
        add_n(5, 6'd0, 8'h10, 3'd5);
        add_n(2, 6'd0, 8'h08, 3'd4);
        add(1'b0, 6'd0, 8'h04, 3'd3);
        // Re-arm from DECAY at peak 3, then full decay to IDLE
        add(1'b0, 6'd48, 8'h3F, 3'd6);
        add_n(5, 6'd0, 8'h20, 3'd6);
        add_n(2, 6'd0, 8'h10, 3'd5);
        add_n(2, 6'd0, 8'h08, 3'd4);
        add_n(2, 6'd0, 8'h04, 3'd3);
        add_n(2, 6'd0, 8'h02, 3'd2);
        add_n(2, 6'd0, 8'h01, 3'd1);
        add(1'b0, 6'd0, 8'h00, 3'd0);
        add(1'b0, 6'd8, 8'h01, 3'd1);
        // Clip with mid-count re-arm
        add(1'b1, 6'd0, 8'h00, 3'd0);
        add(1'b0, 6'd63, 8'hFF, 3'd7);
        add_n(2, 6'd0, 8'hC0, 3'd7);
        add(1'b0, 6'd63, 8'hFF, 3'd7);
        add_n(2, 6'd0, 8'hC0, 3'd7);
        add_n(2, 6'd0, 8'h40, 3'd7);

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                sample(vecs[i].din);
            end
            check("vec_leds", i, leds, vecs[i].exp_leds);
            check("vec_peak", i, peak_lvl, vecs[i].exp_peak);
        end

        // PWM gating with lvl 7 held and no valids
        do_reset();
        sample(6'd56);
        check("pwm_setup", 0, leds, 8'h7F);
        brightness = 4'd4;
        pwm_window("pwm_b4", 4);
        brightness = 4'd0;
        pwm_window("pwm_b0", 0);
        brightness = 4'hF;
        pwm_window("pwm_b15", 16);
        check("pwm_peak", 0, peak_lvl, 3'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
